// File: rtl/bnn_ctrl_pkg.sv
// Shared controller definitions for the BNN datapath: FSM state encoding and
// the default geometry used by the MAC array and the line buffer.
package bnn_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int KERNEL_DEF     = 5;
   localparam int IFMAP_W_DEF    = 28;
   localparam int FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/mac_ifmaps_fifo_ctrl_if.sv
// Control bundle between the ifmaps FIFO controller and its neighbours
// (sequencer, line-buffer source, ifmaps FIFO flags and MAC array).
interface mac_ifmaps_fifo_ctrl_if #(
   parameter int CNT_W = 5
);
   logic             start;
   logic             busy;
   logic             done;
   logic             src_valid;
   logic             src_ready;
   logic             fifo_full;
   logic             fifo_empty;
   logic             ifmaps_input_valid;
   logic             fifo_read;
   logic             mac_ready;
   logic             mac_col_valid;
   logic [CNT_W-1:0] mac_col_idx;
   logic             mac_window_valid;

   modport master (
      input  start, src_valid, fifo_full, fifo_empty, mac_ready,
      output busy, done, src_ready, ifmaps_input_valid, fifo_read,
             mac_col_valid, mac_col_idx, mac_window_valid
   );

   modport slave (
      output start, src_valid, fifo_full, fifo_empty, mac_ready,
      input  busy, done, src_ready, ifmaps_input_valid, fifo_read,
             mac_col_valid, mac_col_idx, mac_window_valid
   );
endinterface

// File: rtl/mac_col_counter.sv
// Saturating column counter: counts enabled cycles up to MAX and holds there;
// tc flags that MAX has been reached. clr restarts it for a new band.
module mac_col_counter #(
   parameter int MAX = 28,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);
   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + W'(1);
      end
   end

   assign tc = (cnt == MAX_V);
endmodule

// File: rtl/mac_ifmaps_fifo_ctrl.sv
// Sequences one row-band of ifmap columns into the MAC ifmaps FIFO and out to
// the MAC array; owns only the FIFO strobes, occupancy and column tagging.
module mac_ifmaps_fifo_ctrl
   import bnn_ctrl_pkg::*;
#(
   parameter int KERNEL     = KERNEL_DEF,
   parameter int IFMAP_W    = IFMAP_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int CNT_W      = $clog2(IFMAP_W + 1),
   parameter int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   mac_ifmaps_fifo_ctrl_if.master bus
);
   localparam int                 N_CNT      = 2;
   localparam logic [OCC_W-1:0]   KERNEL_OCC = OCC_W'(KERNEL);
   localparam logic [CNT_W-1:0]   LAST_COL   = CNT_W'(IFMAP_W - 1);
   localparam logic [CNT_W-1:0]   FIRST_WIN  = CNT_W'(KERNEL - 1);

   state_t             state_reg, state_next;
   logic [OCC_W-1:0]   occ_reg, occ_next;
   logic               col_valid_reg;
   logic [CNT_W-1:0]   col_idx_reg;
   logic               win_valid_reg;

   logic               band_start;
   logic               src_ready;
   logic               wr_en;
   logic               rd_en;
   logic [CNT_W-1:0]   wr_cnt, rd_cnt;
   logic               wr_tc, rd_tc;
   logic [N_CNT-1:0]   cnt_en, cnt_tc;
   logic [CNT_W-1:0]   cnt_val [N_CNT];

   // Slot 0 counts FIFO writes, slot 1 counts FIFO reads.
   assign cnt_en = {rd_en, wr_en};

   generate
      for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
         mac_col_counter #(
            .MAX (IFMAP_W),
            .W   (CNT_W)
         ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (band_start),
            .en  (cnt_en[gi]),
            .cnt (cnt_val[gi]),
            .tc  (cnt_tc[gi])
         );
      end
   endgenerate

   assign wr_cnt = cnt_val[0];
   assign rd_cnt = cnt_val[1];
   assign wr_tc  = cnt_tc[0];
   assign rd_tc  = cnt_tc[1];

   assign band_start = (state_reg == IDLE) && bus.start;
   assign src_ready  = ((state_reg == FILL) || (state_reg == RUN))
                       && !bus.fifo_full && !wr_tc;
   assign wr_en      = bus.src_valid && src_ready;
   assign rd_en      = (state_reg == RUN) && bus.mac_ready
                       && !bus.fifo_empty && !rd_tc;

   always_comb begin
      occ_next = occ_reg;
      if (wr_en && !rd_en) begin
         occ_next = occ_reg + OCC_W'(1);
      end else if (rd_en && !wr_en) begin
         occ_next = occ_reg - OCC_W'(1);
      end
   end

   // FILL looks at the occupancy being registered this cycle so that RUN
   // starts right after the KERNEL-th column lands in the FIFO.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (bus.start) state_next = FILL;
         FILL:  if (occ_next >= KERNEL_OCC) state_next = RUN;
         RUN:   if (rd_en && (rd_cnt == LAST_COL)) state_next = DRAIN;
         DRAIN: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         occ_reg       <= '0;
         col_valid_reg <= 1'b0;
         col_idx_reg   <= '0;
         win_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         occ_reg       <= occ_next;
         col_valid_reg <= rd_en;
         win_valid_reg <= rd_en && (rd_cnt >= FIRST_WIN);
         if (rd_en) begin
            col_idx_reg <= rd_cnt;
         end
      end
   end

   assign bus.busy               = (state_reg != IDLE);
   assign bus.done               = (state_reg == DRAIN);
   assign bus.src_ready          = src_ready;
   assign bus.ifmaps_input_valid = wr_en;
   assign bus.fifo_read          = rd_en;
   assign bus.mac_col_valid      = col_valid_reg;
   assign bus.mac_col_idx        = col_idx_reg;
   assign bus.mac_window_valid   = win_valid_reg;
endmodule

// File: tb/tb_mac_ifmaps_fifo_ctrl.sv
// Bench for mac_ifmaps_fifo_ctrl: a counting FIFO model drives the flags and a
// band-level reference model predicts every control output cycle by cycle.
module tb_mac_ifmaps_fifo_ctrl;
   localparam int K  = 5;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int CW = $clog2(W + 1);
   localparam int VW = 7 + CW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mac_ifmaps_fifo_ctrl_if #(.CNT_W(CW)) bus ();

   mac_ifmaps_fifo_ctrl #(
      .KERNEL     (K),
      .IFMAP_W    (W),
      .FIFO_DEPTH (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // External FIFO: only its fill level matters; flags are registered.
   int env_depth = D;
   int fcnt;
   always @(posedge clk or posedge rst) begin
      if (rst) fcnt <= 0;
      else     fcnt <= fcnt + (bus.ifmaps_input_valid ? 1 : 0) - (bus.fifo_read ? 1 : 0);
   end
   assign bus.fifo_full  = (fcnt >= env_depth);
   assign bus.fifo_empty = (fcnt == 0);

   int n_total = 0;
   int n_bad   = 0;

   // Band-level reference model.
   bit m_active, m_primed, m_drain, m_cv, m_win;
   int m_wr, m_rd, m_idx;

   logic [VW-1:0] act_vec, exp_vec;
   logic          act_busy, act_done, act_sr, act_wr, act_rd, act_cv, act_win;
   logic [CW-1:0] act_idx;

   task automatic model_reset();
      m_active = 0; m_primed = 0; m_drain = 0; m_cv = 0; m_win = 0;
      m_wr = 0; m_rd = 0; m_idx = 0;
   endtask

   task automatic cycle(input bit sv, input bit mr, input bit st);
      bit e_sr, e_wr, e_rd;
      @(negedge clk);
      bus.src_valid = sv;
      bus.mac_ready = mr;
      bus.start     = st;
      #1;
      e_sr = m_active && !m_drain && !bus.fifo_full && (m_wr < W);
      e_wr = sv && e_sr;
      e_rd = m_active && m_primed && !m_drain && mr && !bus.fifo_empty && (m_rd < W);
      exp_vec  = {m_active, m_drain, e_sr, e_wr, e_rd, m_cv, CW'(m_idx), m_win};
      act_busy = bus.busy;      act_done = bus.done;  act_sr = bus.src_ready;
      act_wr   = bus.ifmaps_input_valid;              act_rd = bus.fifo_read;
      act_cv   = bus.mac_col_valid; act_idx = bus.mac_col_idx;
      act_win  = bus.mac_window_valid;
      act_vec  = {act_busy, act_done, act_sr, act_wr, act_rd, act_cv, act_idx, act_win};
      if (act_cv) $display("col idx=%0d window=%0b t=%0t", act_idx, act_win, $time);
      @(posedge clk);
      if (!m_active) begin
         m_cv = 0; m_win = 0;
         if (st) begin
            m_active = 1; m_primed = 0; m_drain = 0; m_wr = 0; m_rd = 0;
         end
      end else if (m_drain) begin
         m_active = 0; m_drain = 0; m_primed = 0; m_cv = 0; m_win = 0;
      end else begin
         m_cv  = e_rd;
         m_win = e_rd && (m_rd >= K - 1);
         if (e_rd) m_idx = m_rd;
         if (e_rd && (m_rd == W - 1)) m_drain = 1;
         m_wr += int'(e_wr);
         m_rd += int'(e_rd);
         if (m_wr - m_rd >= K) m_primed = 1;
      end
   endtask

   task automatic test_reset();
      bit saw_done = 0;
      rst = 1'b1; bus.start = 0; bus.src_valid = 0; bus.mac_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      act_vec = {bus.busy, bus.done, bus.src_ready, bus.ifmaps_input_valid, bus.fifo_read,
                 bus.mac_col_valid, bus.mac_col_idx, bus.mac_window_valid};
      n_total++;
      if (act_vec !== '0 || dut.state_reg !== 2'd0) begin
         n_bad++; $display("FAIL reset_outputs got=%b state=%0d need=0 state=0", act_vec, dut.state_reg);
      end
      rst = 1'b0;
      // Reach RUN with three columns buffered, then reset asynchronously.
      for (int c = 0; c < 9; c++) begin
         cycle(c < 7, 1'b1, c == 0);
         n_total++;
         if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL reset_band c=%0d dut=%b model=%b", c, act_vec, exp_vec);
         end
         if (act_done) saw_done = 1;
      end
      @(negedge clk);
      bus.mac_ready = 0; bus.src_valid = 0;
      n_total++;
      if (dut.occ_reg !== 3 || bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL reset_setup occ=%0d busy=%b need occ=3 busy=1", dut.occ_reg, bus.busy);
      end
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mac_col_valid !== 1'b0 || saw_done) begin
         n_bad++; $display("FAIL reset_async busy=%b done=%b cv=%b saw_done=%b need all 0",
                           bus.busy, bus.done, bus.mac_col_valid, saw_done);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      n_total++;
      if (act_vec !== exp_vec || act_done !== 1'b0) begin
         n_bad++; $display("FAIL reset_after dut=%b model=%b", act_vec, exp_vec);
      end
   endtask

   task automatic test_stream();
      int first_wr = -1, last_wr = -1, n_wr = 0, first_rd = -1, first_cv = -1;
      int done_c = -1, first_win = -1, n_win = 0;
      bit busy15 = 1, ok;
      int idxq[$];
      for (int c = 0; c < 18; c++) begin
         cycle(1'b1, 1'b1, c == 0);
         n_total++;
         if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL stream_cycle c=%0d dut=%b model=%b", c, act_vec, exp_vec);
         end
         if (act_wr) begin if (first_wr < 0) first_wr = c; last_wr = c; n_wr++; end
         if (act_rd && first_rd < 0) first_rd = c;
         if (act_cv) begin if (first_cv < 0) first_cv = c; idxq.push_back(int'(act_idx)); end
         if (act_win) begin if (first_win < 0) first_win = c; n_win++; end
         if (act_done) done_c = c;
         if (c == 15) busy15 = act_busy;
      end
      n_total++;
      if (first_wr !== 1 || last_wr !== 8 || n_wr !== 8) begin
         n_bad++; $display("FAIL stream_writes first=%0d last=%0d n=%0d need 1 8 8", first_wr, last_wr, n_wr);
      end
      n_total++;
      if (first_rd !== 6 || first_cv !== 7) begin
         n_bad++; $display("FAIL stream_first_read rd=%0d cv=%0d need 6 7", first_rd, first_cv);
      end
      n_total++;
      if (first_win !== 11 || n_win !== 4) begin
         n_bad++; $display("FAIL stream_window first=%0d n=%0d need 11 4", first_win, n_win);
      end
      n_total++;
      if (done_c !== 14 || busy15 !== 1'b0) begin
         n_bad++; $display("FAIL stream_done done=%0d busy15=%b need 14 0", done_c, busy15);
      end
      ok = (idxq.size() == W);
      foreach (idxq[i]) if (idxq[i] != i) ok = 0;
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL stream_order got=%p need 0..%0d", idxq, W - 1); end
   endtask

   task automatic test_mac_stall();
      int done_c = -1, stall_rd = 0;
      bit ok;
      int idxq[$];
      for (int c = 0; c < 21; c++) begin
         cycle(1'b1, !(c >= 8 && c <= 10), c == 0);
         n_total++;
         if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL stall_cycle c=%0d dut=%b model=%b", c, act_vec, exp_vec);
         end
         if (act_rd && c >= 8 && c <= 10) stall_rd++;
         if (act_cv) idxq.push_back(int'(act_idx));
         if (act_done) done_c = c;
      end
      n_total++;
      if (stall_rd !== 0 || done_c !== 17) begin
         n_bad++; $display("FAIL stall_timing reads_in_stall=%0d done=%0d need 0 17", stall_rd, done_c);
      end
      ok = (idxq.size() == W);
      foreach (idxq[i]) if (idxq[i] != i) ok = 0;
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL stall_order got=%p need 0..%0d", idxq, W - 1); end
   endtask

   task automatic test_src_gap();
      int resume_idx = -1;
      bit held = 1, ok;
      int idxq[$];
      for (int c = 0; c < 20; c++) begin
         cycle(!(c >= 6 && c <= 11), 1'b1, c == 0);
         n_total++;
         if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL gap_cycle c=%0d dut=%b model=%b", c, act_vec, exp_vec);
         end
         if ((c == 11 || c == 12) && (act_rd !== 1'b0 || act_busy !== 1'b1 || act_done !== 1'b0)) held = 0;
         if (c == 13 && act_rd !== 1'b1) held = 0;
         if (act_cv) idxq.push_back(int'(act_idx));
         if (act_cv && c > 11 && resume_idx < 0) resume_idx = int'(act_idx);
      end
      n_total++;
      if (!held || resume_idx !== 5) begin
         n_bad++; $display("FAIL gap_underflow held=%b resume_idx=%0d need 1 5", held, resume_idx);
      end
      ok = (idxq.size() == W);
      foreach (idxq[i]) if (idxq[i] != i) ok = 0;
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL gap_order got=%p need 0..%0d", idxq, W - 1); end
   endtask

   task automatic test_full_backpressure();
      int n_both = 0, done_c = -1;
      bit closed = 1, ok;
      int idxq[$];
      env_depth = K;
      for (int c = 0; c < 22; c++) begin
         cycle(1'b1, c >= 10, c == 0);
         n_total++;
         if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL full_cycle c=%0d dut=%b model=%b", c, act_vec, exp_vec);
         end
         if (c >= 6 && c <= 10 && act_sr !== 1'b0) closed = 0;
         if (act_wr && act_rd) n_both++;
         if (act_cv) idxq.push_back(int'(act_idx));
         if (act_done) done_c = c;
      end
      env_depth = D;
      n_total++;
      if (!closed || n_both !== 3 || done_c !== 18) begin
         n_bad++; $display("FAIL full_backpressure closed=%b both=%0d done=%0d need 1 3 18", closed, n_both, done_c);
      end
      ok = (idxq.size() == W);
      foreach (idxq[i]) if (idxq[i] != i) ok = 0;
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL full_order got=%p need 0..%0d", idxq, W - 1); end
   endtask

   task automatic test_start_ignored();
      int n_done = 0, late_busy = 0;
      for (int c = 0; c < 20; c++) begin
         cycle(1'b1, 1'b1, c == 0 || c == 2 || c == 14);
         n_total++;
         if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL start_cycle c=%0d dut=%b model=%b", c, act_vec, exp_vec);
         end
         if (act_done) n_done++;
         if (c >= 15 && act_busy) late_busy++;
      end
      n_total++;
      if (n_done !== 1 || late_busy !== 0) begin
         n_bad++; $display("FAIL start_ignored dones=%0d busy_after=%0d need 1 0", n_done, late_busy);
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 6; b++) begin
         int idxq[$];
         int c;
         bit seen_done, timed_out, ok;
         idxq.delete(); c = 0; seen_done = 0; timed_out = 0;
         env_depth = $urandom_range(D, K);
         while (!seen_done) begin
            if (c >= 300) begin
               n_total++; n_bad++; timed_out = 1;
               $display("FAIL random_timeout band=%0d cycles=%0d need done", b, c);
               break;
            end
            cycle($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70,
                  (c == 0) || ($urandom_range(99, 0) < 5));
            n_total++;
            if (act_vec !== exp_vec) begin
               n_bad++; $display("FAIL random_cycle band=%0d c=%0d dut=%b model=%b", b, c, act_vec, exp_vec);
            end
            if (act_cv) idxq.push_back(int'(act_idx));
            if (act_done) seen_done = 1;
            c++;
         end
         if (timed_out) begin
            @(negedge clk); rst = 1'b1; model_reset();
            @(negedge clk); rst = 1'b0;
         end
         repeat (2) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_total++;
            if (act_vec !== exp_vec) begin
               n_bad++; $display("FAIL random_tail band=%0d dut=%b model=%b", b, act_vec, exp_vec);
            end
         end
         ok = (idxq.size() == W);
         foreach (idxq[i]) if (idxq[i] != i) ok = 0;
         n_total++;
         if (!ok) begin n_bad++; $display("FAIL random_order band=%0d got=%p need 0..%0d", b, idxq, W - 1); end
      end
      env_depth = D;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_mac_stall();
      test_src_gap();
      test_full_backpressure();
      test_start_ignored();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "simulation time limit");
   end
endmodule
